// File: rtl/arm_mem_multiport_if.sv
// Request/response bundle for arm_mem_multiport: one valid/ready request and one
// response channel per port, packed port-major (port p at [W*p +: W]).
interface arm_mem_multiport_if #(
    parameter int NPORTS = 2
);
    logic [NPORTS-1:0]    req;
    logic [NPORTS-1:0]    we;
    logic [NPORTS*32-1:0] addr;
    logic [NPORTS*4-1:0]  be;
    logic [NPORTS*32-1:0] wdata;
    logic [NPORTS-1:0]    ready;
    logic [NPORTS-1:0]    rvalid;
    logic [NPORTS*32-1:0] rdata;
    logic [NPORTS-1:0]    excpt;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rvalid, rdata, excpt
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rvalid, rdata, excpt
    );
endinterface

// File: rtl/arm_mem_multiport.sv
// N-port big-endian data/text memory with valid/ready requests, RD_LAT-cycle responses,
// byte-lane writes and same-word write arbitration. Optional MEM_MISALIGN_EXCPT_EN faults misaligned accesses.
module arm_mem_multiport #(
    parameter int          NPORTS     = 2,
    parameter logic [31:0] DATA_START = 32'h1000_0000,
    parameter logic [31:0] DATA_SIZE  = 32'h0000_0100,
    parameter logic [31:0] TEXT_START = 32'h0000_0000,
    parameter logic [31:0] TEXT_SIZE  = 32'h0000_0100,
    parameter int          RD_LAT     = 1
) (
    input logic                 clk,
    input logic                 rst,
    arm_mem_multiport_if.slave  bus
);
    localparam int DWORDS = int'(DATA_SIZE >> 2);
    localparam int TWORDS = int'(TEXT_SIZE >> 2);
    localparam int DIW    = (DWORDS > 1) ? $clog2(DWORDS) : 1;
    localparam int TIW    = (TWORDS > 1) ? $clog2(TWORDS) : 1;

    logic [31:0] dmem [DWORDS];
    logic [31:0] tmem [TWORDS];

    logic [NPORTS-1:0] hit_d;
    logic [NPORTS-1:0] hit_t;
    logic [NPORTS-1:0] fault;
    logic [NPORTS-1:0] acc;
    logic [DIW-1:0]    didx [NPORTS];
    logic [TIW-1:0]    tidx [NPORTS];

    logic [NPORTS-1:0] vld_p0;
    logic [NPORTS-1:0] exc_p0;
    logic [31:0]       rdata_p0 [NPORTS];

    logic [NPORTS-1:0] vld_out;
    logic [NPORTS-1:0] exc_out;
    logic [31:0]       dat_out [NPORTS];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lane_en);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++)
            if (lane_en[b]) w[8*b +: 8] = new_w[8*b +: 8];
        return w;
    endfunction

    // Address decode: data region wins over text; anything else faults.
    always_comb begin
        logic [31:0] a;
        logic [31:0] aw;
        logic [31:0] doff;
        logic [31:0] toff;
        logic        mis;
        logic        in_d;
        logic        in_t;
        hit_d = '0;
        hit_t = '0;
        fault = '0;
        for (int p = 0; p < NPORTS; p++) begin
            a    = bus.addr[32*p +: 32];
            aw   = a & ~32'h3;
`ifdef MEM_MISALIGN_EXCPT_EN
            mis  = |a[1:0];
`else
            mis  = 1'b0;
`endif
            doff = aw - DATA_START;
            toff = aw - TEXT_START;
            in_d = doff < DATA_SIZE;
            in_t = !in_d && (toff < TEXT_SIZE);
            hit_d[p] = in_d && ((doff + 32'd3) < DATA_SIZE) && !mis;
            hit_t[p] = in_t && ((toff + 32'd3) < TEXT_SIZE) && !mis;
            fault[p] = !(hit_d[p] || hit_t[p]);
            didx[p]  = doff[DIW+1:2];
            tidx[p]  = toff[TIW+1:2];
        end
    end

    // Lower-index writer owns a contended word; reads are never held off.
    always_comb begin
        logic coll;
        bus.ready = '0;
        for (int p = 0; p < NPORTS; p++) begin
            coll = 1'b0;
            for (int q = 0; q < NPORTS; q++)
                if (q < p && bus.req[q] && bus.we[q] &&
                    bus.addr[32*q+2 +: 30] == bus.addr[32*p+2 +: 30])
                    coll = 1'b1;
            bus.ready[p] = !rst && !(bus.req[p] && bus.we[p] && coll);
        end
    end

    assign acc = bus.req & bus.ready;

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (acc[p] && bus.we[p]) begin
                if (hit_d[p])
                    dmem[didx[p]] <= merge_lanes(dmem[didx[p]], bus.wdata[32*p +: 32], bus.be[4*p +: 4]);
                else if (hit_t[p])
                    tmem[tidx[p]] <= merge_lanes(tmem[tidx[p]], bus.wdata[32*p +: 32], bus.be[4*p +: 4]);
            end
        end
    end

    // Stage p0: array sampled at the accept edge, before that edge's writes land.
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= '0;
        else     vld_p0 <= acc;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            exc_p0[p] <= fault[p];
            if (bus.we[p] || fault[p]) rdata_p0[p] <= '0;
            else if (hit_d[p])         rdata_p0[p] <= dmem[didx[p]];
            else                       rdata_p0[p] <= tmem[tidx[p]];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [NPORTS-1:0] vld_p1;
            logic [NPORTS-1:0] exc_p1;
            logic [31:0]       rdata_p1 [NPORTS];

            // Stage p1: extra output register.
            always_ff @(posedge clk) begin
                if (rst) vld_p1 <= '0;
                else     vld_p1 <= vld_p0;
            end

            always_ff @(posedge clk) begin
                exc_p1   <= exc_p0;
                rdata_p1 <= rdata_p0;
            end

            assign vld_out = vld_p1;
            assign exc_out = exc_p1;
            assign dat_out = rdata_p1;
        end else begin : g_lat1
            assign vld_out = vld_p0;
            assign exc_out = exc_p0;
            assign dat_out = rdata_p0;
        end
    endgenerate

    // Responses are masked while rst is high so nothing in flight leaks out.
    always_comb begin
        bus.rvalid = '0;
        bus.excpt  = '0;
        bus.rdata  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            bus.rvalid[p]         = vld_out[p] && !rst;
            bus.excpt[p]          = vld_out[p] && !rst && exc_out[p];
            bus.rdata[32*p +: 32] = (vld_out[p] && !rst) ? dat_out[p] : 32'h0;
        end
    end
endmodule

// File: tb/tb_arm_mem_multiport.sv
// Bench for arm_mem_multiport: directed scenarios then random traffic, checked every
// cycle against a byte-addressed reference model.
module tb_arm_mem_multiport;
    localparam int          NP  = 2;
    localparam int          LAT = 1;
    localparam logic [31:0] DS  = 32'h1000_0000;
    localparam logic [31:0] DZ  = 32'h0000_0100;
    localparam logic [31:0] TS  = 32'h0000_0000;
    localparam logic [31:0] TZ  = 32'h0000_0100;

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arm_mem_multiport_if #(.NPORTS(NP)) bus ();

    arm_mem_multiport #(
        .NPORTS(NP), .DATA_START(DS), .DATA_SIZE(DZ),
        .TEXT_START(TS), .TEXT_SIZE(TZ), .RD_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [NP-1:0] req_d = '0;
    logic [NP-1:0] we_d  = '0;
    logic [31:0]   addr_d  [NP];
    logic [31:0]   wdata_d [NP];
    logic [3:0]    be_d    [NP];
    logic [NP-1:0] stall_d = '0;
    logic [NP-1:0] last_ready;

    bit [7:0] bmem [bit [31:0]];
    resp_t    pipe [LAT][NP];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] w, input logic [31:0] base, input logic [31:0] size);
        longint lo, hi, x;
        lo = longint'(base);
        hi = lo + longint'(size);
        x  = longint'(w);
        return (x >= lo) && (x < hi);
    endfunction

    function automatic bit m_fault(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
`ifdef MEM_MISALIGN_EXCPT_EN
        if (a[1:0] != 2'b00) return 1'b1;
`endif
        if (in_range(w, DS, DZ)) return !in_range(w + 32'd3, DS, DZ);
        if (in_range(w, TS, TZ)) return !in_range(w + 32'd3, TS, TZ);
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        return {bmem[w], bmem[w + 1], bmem[w + 2], bmem[w + 3]};
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] lanes);
        logic [31:0] w;
        w = a & ~32'h3;
        for (int k = 0; k < 4; k++)
            if (lanes[3 - k]) bmem[w + k] = d[31 - 8*k -: 8];
    endtask

    task automatic setp(input int p, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] lanes, input logic [31:0] d);
        req_d[p]   = r;
        we_d[p]    = w;
        addr_d[p]  = a;
        be_d[p]    = lanes;
        wdata_d[p] = d;
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) setp(p, 1'b0, 1'b0, DS, 4'h0, 32'h0);
    endtask

    task automatic tick();
        logic [NP-1:0]    rdy_e;
        logic [NP-1:0]    v_e;
        logic [NP-1:0]    e_e;
        logic [NP*32-1:0] d_e;
        resp_t            nr [NP];
        for (int p = 0; p < NP; p++) begin
            bus.req[p]             = req_d[p];
            bus.we[p]              = we_d[p];
            bus.addr[32*p +: 32]   = addr_d[p];
            bus.be[4*p +: 4]       = be_d[p];
            bus.wdata[32*p +: 32]  = wdata_d[p];
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            rdy_e[p] = !rst;
            if (req_d[p] && we_d[p])
                for (int q = 0; q < p; q++)
                    if (req_d[q] && we_d[q] && (addr_d[q] >> 2) == (addr_d[p] >> 2))
                        rdy_e[p] = 1'b0;
        end
        chk("ready", 64'(bus.ready), 64'(rdy_e));
        last_ready = bus.ready;
        for (int p = 0; p < NP; p++) begin
            nr[p] = '0;
            if (req_d[p] && rdy_e[p]) begin
                nr[p].v = 1'b1;
                nr[p].e = m_fault(addr_d[p]);
                if (!we_d[p] && !nr[p].e) nr[p].d = m_read(addr_d[p]);
            end
        end
        for (int p = 0; p < NP; p++)
            if (nr[p].v && we_d[p] && !nr[p].e) m_write(addr_d[p], wdata_d[p], be_d[p]);
        stall_d = req_d & ~rdy_e;
        @(posedge clk);
        for (int s = LAT - 1; s >= 0; s--)
            for (int p = 0; p < NP; p++)
                pipe[s][p] = rst ? '0 : ((s == 0) ? nr[p] : pipe[s - 1][p]);
        #1;
        for (int p = 0; p < NP; p++) begin
            v_e[p]            = pipe[LAT - 1][p].v && !rst;
            e_e[p]            = v_e[p] && pipe[LAT - 1][p].e;
            d_e[32*p +: 32]   = v_e[p] ? pipe[LAT - 1][p].d : 32'h0;
        end
        chk("rvalid", 64'(bus.rvalid), 64'(v_e));
        chk("excpt", 64'(bus.excpt), 64'(e_e));
        chk("rdata", 64'(bus.rdata), 64'(d_e));
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] lo;
        lo = 32'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return DS + 32'($urandom_range(0, 3) * 4) + lo;
            6:                return DS + DZ - 32'd4 + 32'($urandom_range(0, 1) * 4) + lo;
            7:                return TS + 32'($urandom_range(0, 63) * 4) + lo;
            8:                return 32'h2000_0000 + 32'($urandom_range(0, 255));
            default:          return 32'h0FFF_FFFC + lo;
        endcase
    endfunction

    initial begin
        for (int s = 0; s < LAT; s++)
            for (int p = 0; p < NP; p++) pipe[s][p] = '0;
        idle();

        // Reset held with every port requesting.
        rst = 1'b1;
        for (int p = 0; p < NP; p++) setp(p, 1'b1, 1'b0, DS, 4'hF, 32'h0);
        repeat (3) tick();
        chk("rst_ready", 64'(last_ready), 64'h0);
        rst = 1'b0;
        idle();
        tick();

        // Fill both regions so every later read has a defined model value.
        for (int i = 0; i < 64; i++) begin
            setp(0, 1'b1, 1'b1, DS + 32'(i * 4), 4'hF, $urandom);
            setp(1, 1'b1, 1'b1, TS + 32'(i * 4), 4'hF, $urandom);
            tick();
        end
        idle();
        tick();

        // Full-word write then read back.
        setp(0, 1'b1, 1'b1, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF);
        tick();
        setp(0, 1'b1, 1'b0, 32'h1000_0004, 4'h0, 32'h0);
        tick();
        chk("t2_rvalid", 64'(bus.rvalid[0]), 64'h1);
        chk("t2_rdata", 64'(bus.rdata[31:0]), 64'hDEAD_BEEF);
        idle();
        tick();

        // Byte-lane merge.
        setp(0, 1'b1, 1'b1, 32'h1000_000C, 4'hF, 32'h1122_3344);
        tick();
        setp(0, 1'b1, 1'b1, 32'h1000_000C, 4'b0101, 32'hAABB_CCDD);
        tick();
        setp(0, 1'b1, 1'b0, 32'h1000_000C, 4'h0, 32'h0);
        tick();
        chk("t3_merge", 64'(bus.rdata[31:0]), 64'h11BB_33DD);

        // Same-word write collision: port 1 waits one cycle, its data lands last.
        setp(0, 1'b1, 1'b1, 32'h1000_0008, 4'hF, 32'h0000_0001);
        setp(1, 1'b1, 1'b1, 32'h1000_0008, 4'hF, 32'h0000_0002);
        tick();
        chk("t4_stall", 64'(last_ready), 64'h1);
        setp(0, 1'b0, 1'b0, DS, 4'h0, 32'h0);
        tick();
        chk("t4_accept", 64'(last_ready[1]), 64'h1);
        idle();
        setp(0, 1'b1, 1'b0, 32'h1000_0008, 4'h0, 32'h0);
        tick();
        chk("t4_final", 64'(bus.rdata[31:0]), 64'h0000_0002);

        // Read colliding with a same-cycle write sees the old value.
        setp(0, 1'b1, 1'b1, 32'h1000_0004, 4'hF, 32'h5555_AAAA);
        setp(1, 1'b1, 1'b0, 32'h1000_0004, 4'h0, 32'h0);
        tick();
        chk("rw_old", 64'(bus.rdata[63:32]), 64'hDEAD_BEEF);

        // Unmapped address faults on read and write; boundary words.
        idle();
        setp(0, 1'b1, 1'b0, 32'h2000_0000, 4'h0, 32'h0);
        setp(1, 1'b1, 1'b1, 32'h2000_0000, 4'hF, 32'hFFFF_FFFF);
        tick();
        chk("t5_excpt", 64'(bus.excpt), 64'h3);
        chk("t5_rdata", 64'(bus.rdata), 64'h0);
        setp(0, 1'b1, 1'b0, 32'h1000_0100, 4'h0, 32'h0);
        setp(1, 1'b1, 1'b0, 32'h0000_00FC, 4'h0, 32'h0);
        tick();
        chk("past_top", 64'(bus.excpt), 64'h1);

        // Misaligned read.
        idle();
        setp(0, 1'b1, 1'b1, 32'h1000_0000, 4'hF, 32'h0BAD_F00D);
        tick();
        setp(0, 1'b1, 1'b0, 32'h1000_0001, 4'h0, 32'h0);
        tick();
`ifdef MEM_MISALIGN_EXCPT_EN
        chk("t6_excpt", 64'(bus.excpt[0]), 64'h1);
`else
        chk("t6_rdata", 64'(bus.rdata[31:0]), 64'h0BAD_F00D);
`endif

        // Reset mid-operation drops in-flight responses.
        setp(0, 1'b1, 1'b0, 32'h1000_0004, 4'h0, 32'h0);
        setp(1, 1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        tick();
        chk("rst_flush", 64'(bus.rvalid), 64'h0);

        // Random traffic; a stalled port holds its request.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++)
                if (!stall_d[p])
                    setp(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                         rnd_addr(), 4'($urandom_range(0, 15)), $urandom);
            tick();
        end
        idle();
        repeat (LAT + 1) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
